// File: rtl/d_branch_ctrl.sv
// D-stage branch sequencing: pending-write scoreboard, hazard stall, compare gating, delay-slot tracking.
// Optional performance counters are enabled by defining BR_PERF_EN.
module d_branch_ctrl #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 2,
  parameter int MAX_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic             D_is_branch,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_we,
  input  logic [4:0]       D_wa,
  input  logic [LAT_W-1:0] D_lat,
  input  logic             cmp_taken,
  output logic             stall,
  output logic             cmp_en,
  output logic             redirect,
  output logic             in_slot,
  output logic             err
`ifdef BR_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_br,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  // state | meaning
  // IDLE  | no branch pending
  // WAIT  | branch held in D until its operands become forwardable
  // SLOT  | D holds the delay slot of a taken branch
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SLOT = 2'd2
  } state_t;

  localparam int WC_W = $clog2(MAX_LAT + 2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LAT_W-1:0]  r_cnt [NREG];
  logic [WC_W-1:0]   r_wait_cnt;
  logic [WC_W-1:0]   w_wait_nxt;
  logic              r_in_slot;
  logic              r_err;

  logic              w_rs_pend;
  logic              w_rt_pend;
  logic              w_hazard;
  logic              w_issue;
  logic              w_cmp_en;
  logic              w_redirect;
  logic [LAT_W-1:0]  w_lat_clamp;
  logic              w_sb_write;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic              w_slot_br;
  logic              w_wdog;

  assign w_rs_pend = (D_rs != 5'd0) && (r_cnt[D_rs] != '0);
  assign w_rt_pend = (D_rt != 5'd0) && (r_cnt[D_rt] != '0);
  assign w_hazard  = D_valid && D_is_branch && (w_rs_pend || w_rt_pend);
  assign w_issue   = D_valid && !w_hazard;

  assign w_cmp_en   = D_valid && D_is_branch && !w_hazard && (r_state != S_SLOT);
  assign w_redirect = w_cmp_en && cmp_taken;

  assign stall    = w_hazard;
  assign cmp_en   = w_cmp_en;
  assign redirect = w_redirect;
  assign in_slot  = r_in_slot;
  assign err      = r_err;

  assign w_lat_clamp = (D_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : D_lat;
  // Branches never write a GPR, so their D_we is disregarded.
  assign w_sb_write  = w_issue && D_we && !D_is_branch && (D_wa != 5'd0) && (w_lat_clamp != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          r_cnt[r] <= '0;
        else if (w_sb_write && (D_wa == 5'(r)))
          r_cnt[r] <= w_lat_clamp;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_inc  = 1'b0;
    w_wait_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hazard)        w_state_nxt = S_WAIT;
        else if (w_redirect) w_state_nxt = S_SLOT;
      end
      S_WAIT: begin
        if (w_hazard) begin
          w_wait_inc = 1'b1;
        end else begin
          w_wait_clr  = 1'b1;
          w_state_nxt = w_redirect ? S_SLOT : S_IDLE;
        end
      end
      S_SLOT: begin
        if (w_issue) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wait_nxt = r_wait_cnt + 1'b1;
  // Legal latencies never let the counter get this far; reaching it flags a stuck stall.
  assign w_wdog     = w_wait_inc && (w_wait_nxt == WC_W'(MAX_LAT + 1));
  assign w_slot_br  = (r_state == S_SLOT) && D_valid && D_is_branch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_in_slot  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_slot <= (w_state_nxt == S_SLOT);
      if (w_wait_clr)
        r_wait_cnt <= '0;
      else if (w_wait_inc && (r_wait_cnt != WC_W'(MAX_LAT + 1)))
        r_wait_cnt <= w_wait_nxt;
      if (w_slot_br || w_wdog)
        r_err <= 1'b1;
    end
  end

`ifdef BR_PERF_EN
  logic [CNT_W-1:0] r_perf_br;
  logic [CNT_W-1:0] r_perf_taken;
  logic [CNT_W-1:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_br    <= '0;
      r_perf_taken <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_cmp_en && (r_perf_br != '1))      r_perf_br    <= r_perf_br + 1'b1;
      if (w_redirect && (r_perf_taken != '1)) r_perf_taken <= r_perf_taken + 1'b1;
      if (w_hazard && (r_perf_stall != '1))   r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_br    = r_perf_br;
  assign perf_taken = r_perf_taken;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Self-checking bench for d_branch_ctrl: per-cycle expectations queued at drive time, popped at sample time.
module tb_d_branch_ctrl;

  logic       clk;
  logic       reset;
  logic       D_valid;
  logic       D_is_branch;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic       D_we;
  logic [4:0] D_wa;
  logic [1:0] D_lat;
  logic       cmp_taken;
  logic       stall;
  logic       cmp_en;
  logic       redirect;
  logic       in_slot;
  logic       err;
`ifdef BR_PERF_EN
  logic [15:0] perf_br;
  logic [15:0] perf_taken;
  logic [15:0] perf_stall;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic  st;
    logic  ce;
    logic  rd;
    logic  sl;
    logic  er;
    string nm;
  } exp_t;

  exp_t sb[$];

  d_branch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_valid    (D_valid),
    .D_is_branch(D_is_branch),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_we       (D_we),
    .D_wa       (D_wa),
    .D_lat      (D_lat),
    .cmp_taken  (cmp_taken),
    .stall      (stall),
    .cmp_en     (cmp_en),
    .redirect   (redirect),
    .in_slot    (in_slot),
    .err        (err)
`ifdef BR_PERF_EN
    ,
    .perf_br    (perf_br),
    .perf_taken (perf_taken),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One D-stage cycle: drive at negedge, check combinational outputs mid-cycle,
  // then registered outputs just after the rising edge.
  task automatic cyc(input logic v, input logic br, input logic [4:0] rs, input logic [4:0] rt,
                     input logic we, input logic [4:0] wa, input logic [1:0] lat, input logic tk,
                     input logic e_st, input logic e_ce, input logic e_rd,
                     input logic e_sl, input logic e_er, input string nm);
    exp_t e;
    @(negedge clk);
    D_valid = v; D_is_branch = br; D_rs = rs; D_rt = rt;
    D_we = we; D_wa = wa; D_lat = lat; cmp_taken = tk;
    sb.push_back('{e_st, e_ce, e_rd, e_sl, e_er, nm});
    #1;
    e = sb.pop_front();
    n_chk++;
    if (stall !== e.st) begin
      n_err++; $display("FAIL %s stall got %0b exp %0b", e.nm, stall, e.st);
    end
    n_chk++;
    if (cmp_en !== e.ce) begin
      n_err++; $display("FAIL %s cmp_en got %0b exp %0b", e.nm, cmp_en, e.ce);
    end
    n_chk++;
    if (redirect !== e.rd) begin
      n_err++; $display("FAIL %s redirect got %0b exp %0b", e.nm, redirect, e.rd);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (in_slot !== e.sl) begin
      n_err++; $display("FAIL %s in_slot got %0b exp %0b", e.nm, in_slot, e.sl);
    end
    n_chk++;
    if (err !== e.er) begin
      n_err++; $display("FAIL %s err got %0b exp %0b", e.nm, err, e.er);
    end
  endtask

  task automatic nop(input logic e_er, input string nm);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_er, nm);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    D_valid = 1'b1; D_is_branch = 1'b1; D_rs = 5; D_rt = 6;
    D_we = 0; D_wa = 0; D_lat = 0; cmp_taken = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    D_valid = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0b exp 0", stall); end
    n_chk++;
    if (cmp_en !== 1'b0) begin n_err++; $display("FAIL rst_cmp_en got %0b exp 0", cmp_en); end
    n_chk++;
    if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %0b exp 0", err); end
    n_chk++;
    if (in_slot !== 1'b0) begin n_err++; $display("FAIL rst_in_slot got %0b exp 0", in_slot); end
    cyc(0, 1, 5, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, "invalid_d");
  endtask

  task automatic test_load_hazard;
    cyc(1, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0, "lw5");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, "beq5_stall1");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, "beq5_stall2");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 0, 1, 1, 1, 0, "beq5_taken");
    nop(0, "lw_slot_nop");
  endtask

  task automatic test_alu_hazard;
    cyc(1, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, "addu7");
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "bne7_stall");
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "bne7_eval");
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "addu0");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "bne0_nostall");
  endtask

  task automatic test_lat_edges;
    cyc(1, 0, 0, 0, 1, 9, 3, 0, 0, 0, 0, 0, 0, "lat3_clamp");
    cyc(1, 1, 6, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, "clamp_stall1");
    cyc(1, 1, 6, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, "clamp_stall2");
    cyc(1, 1, 6, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, "clamp_eval");
    cyc(1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, "lat0_write");
    cyc(1, 1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "lat0_nostall");
    cyc(1, 1, 0, 0, 1, 11, 2, 0, 0, 1, 0, 0, 0, "br_we_ignored");
    cyc(1, 1, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "br_we_nostall");
    cyc(1, 0, 0, 0, 1, 12, 2, 0, 0, 0, 0, 0, 0, "lw12");
    cyc(1, 0, 12, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, "nonbr_nostall");
    nop(0, "drain");
  endtask

  task automatic test_delay_slot;
    cyc(1, 1, 1, 2, 0, 0, 0, 1, 0, 1, 1, 1, 0, "ds_taken");
    cyc(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, "ds_bubble");
    cyc(1, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1, "ds_branch");
    nop(1, "err_sticky1");
    nop(1, "err_sticky2");
  endtask

  task automatic test_reset_in_wait;
    cyc(1, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 1, "rw_lw5");
    cyc(1, 1, 5, 6, 0, 0, 0, 0, 1, 0, 0, 0, 1, "rw_stall");
    @(negedge clk);
    reset = 1'b0;
    D_valid = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (err !== 1'b0) begin n_err++; $display("FAIL rw_err_clr got %0b exp 0", err); end
    n_chk++;
    if (in_slot !== 1'b0) begin n_err++; $display("FAIL rw_slot_clr got %0b exp 0", in_slot); end
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 1, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_beq5_clear");
  endtask

  task automatic test_back_to_back;
    cyc(1, 1, 3, 4, 0, 0, 0, 1, 0, 1, 1, 1, 0, "b2b_t1");
    nop(0, "b2b_slot1");
    cyc(1, 1, 3, 4, 0, 0, 0, 1, 0, 1, 1, 1, 0, "b2b_t2");
    cyc(1, 0, 0, 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, "b2b_slot_wr");
    cyc(1, 1, 13, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "b2b_slot_wr_haz");
    cyc(1, 1, 13, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, "b2b_t3");
    nop(0, "b2b_slot3");
  endtask

`ifdef BR_PERF_EN
  task automatic test_perf;
    @(negedge clk);
    reset = 1'b0;
    D_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0, "pf_lw5");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, "pf_s1");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, "pf_s2");
    cyc(1, 1, 5, 6, 0, 0, 0, 1, 0, 1, 1, 1, 0, "pf_b1");
    nop(0, "pf_slot1");
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, "pf_b2");
    nop(0, "pf_slot2");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "pf_b3");
    n_chk++;
    if (perf_br !== 16'd3) begin n_err++; $display("FAIL perf_br got %0d exp 3", perf_br); end
    n_chk++;
    if (perf_taken !== 16'd2) begin n_err++; $display("FAIL perf_taken got %0d exp 2", perf_taken); end
    n_chk++;
    if (perf_stall !== 16'd2) begin n_err++; $display("FAIL perf_stall got %0d exp 2", perf_stall); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    D_valid = 0; D_is_branch = 0; D_rs = 0; D_rt = 0;
    D_we = 0; D_wa = 0; D_lat = 0; cmp_taken = 0;
    test_reset();
    test_load_hazard();
    test_alu_hazard();
    test_lat_edges();
    test_back_to_back();
    test_delay_slot();
    test_reset_in_wait();
`ifdef BR_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
